// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// ---------------
// Pipeline stage register with a valid/ready handshake and a two-entry
// skid buffer. A beat is stored in the main slot, which drives out_*, and
// a second beat is parked in the skid slot when downstream stalls. This
// lets in_ready be a plain decode of the state flops, with no
// combinational path from out_ready. Flush empties the stage and makes
// the output show a NOP bubble. Two saturating counters report stall and
// flush cycles.
//
// Ports:
//   clk        - the only clock
//   reset      - synchronous, active-high; has priority over flush
//   flush      - drop every stored beat and the incoming beat this cycle
//   in_valid   - upstream beat present
//   in_ready   - registered; the stage can accept a beat
//   in_ctrl    - upstream control payload (CTRL_W bits)
//   in_data    - upstream data payload (DATA_W bits)
//   out_valid  - registered; a beat is presented downstream
//   out_ready  - downstream accepts the beat
//   out_ctrl   - downstream control payload, CTRL_NOP when not valid
//   out_data   - downstream data payload
//   occupancy  - number of stored beats, 0..2
//   stall_cnt  - saturating count of cycles with out_valid & ~out_ready
//   flush_cnt  - saturating count of cycles with flush high

module pipe_stage_skid #(
    parameter int                 CTRL_W     = 16,
    parameter int                 DATA_W     = 128,
    parameter logic [CTRL_W-1:0]  CTRL_NOP   = '1,
    parameter bit                 CLEAR_DATA = 1'b1,
    parameter int                 CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q;
    state_t            state_d;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              push;
    logic              pop;

    // Handshake events. in_ready and out_valid are decoded from the state
    // flops, so both are registered signals.
    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // State register. Reset wins over everything; flush is folded into the
    // next-state logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Flush always lands in EMPTY, dropping any push; a
    // pop in the same cycle has already been taken by the consumer. FULL
    // can never see a push because in_ready is low there.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) state_d = ONE;
                end
                ONE: begin
                    if (push && !pop)      state_d = FULL;
                    else if (!push && pop) state_d = EMPTY;
                end
                FULL: begin
                    if (pop) state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Output decode. All of these depend only on flops, so there is no
    // combinational path from any input to any output.
    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        out_ctrl  = main_ctrl;
        out_data  = main_data;
        case (state_q)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Payload slots. A slot that becomes empty gets CTRL_NOP, so out_ctrl
    // shows a NOP whenever out_valid is low. Data is zeroed on drain or
    // flush only when CLEAR_DATA is set, but always on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_ctrl <= CTRL_NOP;
            main_data <= '0;
            skid_ctrl <= CTRL_NOP;
            skid_data <= '0;
        end else if (flush) begin
            main_ctrl <= CTRL_NOP;
            skid_ctrl <= CTRL_NOP;
            if (CLEAR_DATA) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (push) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end else if (pop) begin
                        main_ctrl <= CTRL_NOP;
                        if (CLEAR_DATA) main_data <= '0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        skid_ctrl <= CTRL_NOP;
                        if (CLEAR_DATA) skid_data <= '0;
                    end
                end
                default: begin
                    main_ctrl <= CTRL_NOP;
                    skid_ctrl <= CTRL_NOP;
                end
            endcase
        end
    end

    // Performance counters. They stick at all ones and are cleared only by
    // reset, never by flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
// ------------------
// Directed bench for pipe_stage_skid with 16-bit control, 128-bit data and
// 4-bit counters. Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, away from the active edge.

module tb_pipe_stage_skid;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_ctrl;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_ctrl;
    logic [127:0] out_data;
    logic [1:0]   occupancy;
    logic [3:0]   stall_cnt;
    logic [3:0]   flush_cnt;

    int checks;
    int errors;

    pipe_stage_skid #(
        .CTRL_W     (16),
        .DATA_W     (128),
        .CTRL_NOP   (16'hFFFF),
        .CLEAR_DATA (1'b1),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held two cycles with in_valid high; nothing may be accepted.
    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 16'h0055; in_data = 128'h55;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_ctrl !== 16'hFFFF || occupancy !== 2'd0 ||
                in_ready !== 1'b1 || out_data !== 128'h0) begin
                $display("[TB] FAIL reset_state cyc%0d: valid=%b ctrl=%h occ=%0d rdy=%b data=%h, want 0 FFFF 0 1 0",
                         i, out_valid, out_ctrl, occupancy, in_ready, out_data);
                errors++;
            end
            checks++;
            if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
                $display("[TB] FAIL reset_counters: stall=%0d flush=%0d, want 0 0", stall_cnt, flush_cnt);
                errors++;
            end
        end
        reset = 1'b0; in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            $display("[TB] FAIL reset_idle: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
            errors++;
        end
    endtask

    // Three back-to-back beats with out_ready high: one-cycle latency, no
    // bubble, occupancy stays at 1.
    task automatic test_streaming();
        logic [15:0]  exp_ctrl [3];
        logic [127:0] exp_data [3];
        exp_ctrl = '{16'd1, 16'd2, 16'd3};
        exp_data = '{128'hA, 128'hB, 128'hC};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_ctrl = exp_ctrl[i]; in_data = exp_data[i];
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ctrl !== exp_ctrl[i] || out_data !== exp_data[i] ||
                occupancy !== 2'd1 || in_ready !== 1'b1) begin
                $display("[TB] FAIL stream_beat%0d: valid=%b ctrl=%h data=%h occ=%0d rdy=%b, want 1 %h %h 1 1",
                         i, out_valid, out_ctrl, out_data, occupancy, in_ready, exp_ctrl[i], exp_data[i]);
                errors++;
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'hFFFF || out_data !== 128'h0 || occupancy !== 2'd0) begin
            $display("[TB] FAIL stream_drain: valid=%b ctrl=%h data=%h occ=%0d, want 0 FFFF 0 0",
                     out_valid, out_ctrl, out_data, occupancy);
            errors++;
        end
        checks++;
        if (stall_cnt !== 4'd0) begin
            $display("[TB] FAIL stream_stall_cnt: got %0d, want 0", stall_cnt);
            errors++;
        end
    endtask

    // Downstream stalls while 5, 6, 7 are offered: 5 and 6 fill the stage,
    // 7 waits upstream, then the stage drains in order 5, 6, 7.
    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 16'd5; in_data = 128'h5;
        tick();
        checks++;
        if (out_ctrl !== 16'd5 || out_data !== 128'h5 || in_ready !== 1'b1 || occupancy !== 2'd1 || stall_cnt !== 4'd0) begin
            $display("[TB] FAIL bp_first: ctrl=%h data=%h rdy=%b occ=%0d stall=%0d, want 5 5 1 1 0",
                     out_ctrl, out_data, in_ready, occupancy, stall_cnt);
            errors++;
        end
        in_ctrl = 16'd6; in_data = 128'h6;
        tick();
        checks++;
        if (out_ctrl !== 16'd5 || in_ready !== 1'b0 || occupancy !== 2'd2 || stall_cnt !== 4'd1) begin
            $display("[TB] FAIL bp_full: ctrl=%h rdy=%b occ=%0d stall=%0d, want 5 0 2 1",
                     out_ctrl, in_ready, occupancy, stall_cnt);
            errors++;
        end
        in_ctrl = 16'd7; in_data = 128'h7;
        tick();
        tick();
        checks++;
        if (out_ctrl !== 16'd5 || in_ready !== 1'b0 || occupancy !== 2'd2 || stall_cnt !== 4'd3) begin
            $display("[TB] FAIL bp_hold: ctrl=%h rdy=%b occ=%0d stall=%0d, want 5 0 2 3",
                     out_ctrl, in_ready, occupancy, stall_cnt);
            errors++;
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 16'd6 || out_data !== 128'h6 || in_ready !== 1'b1 ||
            occupancy !== 2'd1 || stall_cnt !== 4'd3) begin
            $display("[TB] FAIL bp_drain_skid: valid=%b ctrl=%h data=%h rdy=%b occ=%0d stall=%0d, want 1 6 6 1 1 3",
                     out_valid, out_ctrl, out_data, in_ready, occupancy, stall_cnt);
            errors++;
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 16'd7 || out_data !== 128'h7 || occupancy !== 2'd1) begin
            $display("[TB] FAIL bp_held_beat: valid=%b ctrl=%h data=%h occ=%0d, want 1 7 7 1",
                     out_valid, out_ctrl, out_data, occupancy);
            errors++;
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            $display("[TB] FAIL bp_empty: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
            errors++;
        end
    endtask

    // Flush while FULL with a push and a pop in the same cycle.
    task automatic test_flush_full();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 16'd8; in_data = 128'h8;
        tick();
        in_ctrl = 16'd9; in_data = 128'h9;
        tick();
        checks++;
        if (occupancy !== 2'd2 || stall_cnt !== 4'd4) begin
            $display("[TB] FAIL flush_setup: occ=%0d stall=%0d, want 2 4", occupancy, stall_cnt);
            errors++;
        end
        flush = 1'b1; out_ready = 1'b1;
        in_ctrl = 16'h00AA; in_data = 128'hAA;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'hFFFF || out_data !== 128'h0 || occupancy !== 2'd0 ||
            in_ready !== 1'b1) begin
            $display("[TB] FAIL flush_state: valid=%b ctrl=%h data=%h occ=%0d rdy=%b, want 0 FFFF 0 0 1",
                     out_valid, out_ctrl, out_data, occupancy, in_ready);
            errors++;
        end
        checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd4) begin
            $display("[TB] FAIL flush_counters: flush=%0d stall=%0d, want 1 4", flush_cnt, stall_cnt);
            errors++;
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            $display("[TB] FAIL flush_dropped: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
            errors++;
        end
    endtask

    // Stall 20 cycles on one beat; the 4-bit counter goes 4 -> 15 and sticks.
    task automatic test_counter_saturation();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 16'h0011; in_data = 128'h11;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (stall_cnt !== 4'd14) begin
            $display("[TB] FAIL sat_before: got %0d, want 14", stall_cnt);
            errors++;
        end
        tick();
        checks++;
        if (stall_cnt !== 4'd15) begin
            $display("[TB] FAIL sat_reach: got %0d, want 15", stall_cnt);
            errors++;
        end
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (stall_cnt !== 4'd15 || out_ctrl !== 16'h0011) begin
            $display("[TB] FAIL sat_hold: stall=%0d ctrl=%h, want 15 0011", stall_cnt, out_ctrl);
            errors++;
        end
    endtask

    // Reset from FULL, then a fresh beat must appear after one cycle.
    task automatic test_mid_reset();
        in_valid = 1'b1; in_ctrl = 16'h0012; in_data = 128'h12;
        tick();
        checks++;
        if (occupancy !== 2'd2) begin
            $display("[TB] FAIL midrst_setup: occ=%0d, want 2", occupancy);
            errors++;
        end
        reset = 1'b1; out_ready = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== 16'hFFFF || out_data !== 128'h0 ||
            occupancy !== 2'd0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            $display("[TB] FAIL midrst_state: valid=%b rdy=%b ctrl=%h data=%h occ=%0d stall=%0d flush=%0d, want 0 1 FFFF 0 0 0 0",
                     out_valid, in_ready, out_ctrl, out_data, occupancy, stall_cnt, flush_cnt);
            errors++;
        end
        in_ctrl = 16'h0021; in_data = 128'h21;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 16'h0021 || out_data !== 128'h21 || occupancy !== 2'd1) begin
            $display("[TB] FAIL midrst_push: valid=%b ctrl=%h data=%h occ=%0d, want 1 0021 21 1",
                     out_valid, out_ctrl, out_data, occupancy);
            errors++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_counter_saturation();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It is the successor to the fixed-format stage registers between decode, execute, memory and writeback. Control and data payloads are generic buses. Stalls propagate through the handshake, so no global enable is needed, and `in_ready` is fully registered. Flush inserts a NOP bubble. Saturating stall and flush counters feed the performance monitors.

## Interface
Parameters:
- `CTRL_W`, default 16: control payload width (RegWrite, ResultSrc, ALUControl, and so on, packed by the instantiating stage).
- `DATA_W`, default 128: data payload width (operands, PC, PC+4, immediate, register indices).
- `CTRL_NOP`, default all ones in `CTRL_W` bits: control value driven on any empty or flushed slot.
- `CLEAR_DATA`, default 1: when 1, data slots are zeroed on reset, flush and drain; when 0, data holds its last value.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`, input, 1: the only clock.
- `reset`, input, 1: synchronous, active-high.
- `flush`, input, 1: discards all stored beats and the incoming beat this cycle.
- `in_valid`, input, 1: upstream beat present.
- `in_ready`, output, 1: registered; stage can accept a beat.
- `in_ctrl`, input, `CTRL_W`: upstream control payload.
- `in_data`, input, `DATA_W`: upstream data payload.
- `out_valid`, output, 1: registered; a beat is presented downstream.
- `out_ready`, input, 1: downstream accepts the beat.
- `out_ctrl`, output, `CTRL_W`: downstream control payload.
- `out_data`, output, `DATA_W`: downstream data payload.
- `occupancy`, output, 2: number of stored beats, 0 to 2.
- `stall_cnt`, output, `CNT_W`: saturating count of cycles with `out_valid` high and `out_ready` low.
- `flush_cnt`, output, `CNT_W`: saturating count of cycles with `flush` high.

## Operation
- Storage is a main slot, which drives `out_*`, plus a skid slot. The FSM has three states: EMPTY, ONE and FULL.
- A push occurs when `in_valid & in_ready`. A pop occurs when `out_valid & out_ready`.
- In EMPTY:
  - Push: main <= in, go to ONE.
  - No push: stay in EMPTY.
- In ONE:
  - Push and pop: main <= in, stay in ONE.
  - Push only: skid <= in, go to FULL.
  - Pop only: go to EMPTY, main ctrl <= `CTRL_NOP`, main data <= 0 if `CLEAR_DATA`.
  - Neither: hold.
- In FULL (`in_ready` is 0, so no push can occur):
  - Pop: main <= skid, skid ctrl <= `CTRL_NOP`, go to ONE.
  - No pop: hold.
- `in_ready` is 1 in EMPTY and ONE and 0 in FULL. It is a flop driven by the next state and never combinational from `out_ready`.
- `out_valid` is 1 in ONE and FULL. When `out_valid` is 0, `out_ctrl` equals `CTRL_NOP`.
- `occupancy` is 0, 1 or 2 for EMPTY, ONE or FULL.
- Flush has priority over push and pop:
  - Next state is EMPTY and both slots are cleared.
  - A downstream pop in the flush cycle still counts as completed; the consumer keeps that beat.
  - An upstream push in the flush cycle is dropped.
  - `in_ready` is 1 on the cycle after the flush.
- Reset has priority over flush. Everything returns to its reset values, and counters are cleared only by reset.
- `stall_cnt` and `flush_cnt` increment by 1 per qualifying cycle and hold at 2^`CNT_W`-1.
- Pushes and pops that occur while reset is high are ignored.

## Timing
- Reset values, all taking effect at the first clock edge with `reset` high:
  - `out_valid` = 0
  - `in_ready` = 1
  - `out_ctrl` = `CTRL_NOP`
  - `out_data` = 0
  - `occupancy` = 0
  - `stall_cnt` = 0
  - `flush_cnt` = 0
  - Internal skid slot: ctrl = `CTRL_NOP`, data = 0.
- Latency: a beat pushed at edge N appears on `out_*` with `out_valid` = 1 after edge N, i.e. 1 cycle.
- Throughput: 1 beat per cycle while `out_ready` stays high. No bubble is inserted in ONE with push and pop together.
- Backpressure:
  - Beats are absorbed by the skid slot, so `in_ready` falls one cycle after `out_ready` falls.
  - With `out_ready` low and `in_valid` continuously high, exactly two beats are accepted.
- Draining: after `out_ready` returns high from FULL, `in_ready` is 1 on the next cycle and data order is preserved (main first, then skid).
- All outputs are registered. There is no combinational path from input to output.

## Test plan
- Reset and idle:
  - Stimulus: hold `reset` for 2 cycles with `in_valid` = 1, then release.
  - Response: during reset, `out_valid` = 0, `out_ctrl` = 16'hFFFF, `occupancy` = 0 and `in_ready` = 1; nothing is accepted before release.
- Streaming:
  - Stimulus: push ctrl 1, 2, 3 (data 0xA, 0xB, 0xC) on consecutive cycles with `out_ready` = 1.
  - Response: `out_ctrl` shows 1, 2, 3 one cycle later each, `occupancy` stays 1 and `stall_cnt` = 0.
- Backpressure and skid:
  - Stimulus: `out_ready` = 0 while pushing 5, 6, 7.
  - Response: 5 and 6 are accepted, `in_ready` = 0 with `occupancy` = 2 and 7 is held upstream, `stall_cnt` increments every cycle. After `out_ready` = 1, the outputs are 5, 6, 7 in order.
- Flush in FULL:
  - Stimulus: in state FULL, assert `flush` together with `in_valid` and `out_ready` = 1.
  - Response: the beat on `out_*` counts as consumed, the incoming beat is dropped. Next cycle `out_valid` = 0, `out_ctrl` = 16'hFFFF, `out_data` = 0, `occupancy` = 0 and `flush_cnt` = 1.
- Counter saturation:
  - Stimulus: with `CNT_W` = 4, stall for 20 cycles.
  - Response: `stall_cnt` stops at 15.
- Mid-operation reset:
  - Stimulus: in FULL, assert `reset` for 1 cycle.
  - Response: all outputs return to their reset values, the counters are cleared, and a subsequent push appears after 1 cycle.
